vending_ctrl: RTL and testbench
===============================

# vending_ctrl

Parametrised vending-machine controller, successor to the fixed single-item `vending` block. It accumulates coin credit, validates a slot selection against per-slot price and stock, and runs a dispense handshake. It then returns change as a coin-by-coin stream. It sits between the coin acceptor / keypad front end and the motor and coin-hopper drivers.

## Interface
- `N_SLOTS`, default 8: number of product slots.
- `PRICE_W`, default 10: width of each price, in cents.
- `CREDIT_W`, default 11: width of the credit register, in cents.
- `MAX_CREDIT`, default 1000: credit ceiling, in cents.
- `STOCK_W`, default 4: width of each per-slot stock counter. Saturates at 2^STOCK_W-1.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `coin_valid` in 1: one coin inserted this cycle.
- `coin_type` in 2: 0 = nickel (5), 1 = dime (10), 2 = quarter (25), 3 = dollar (100).
- `sel_valid` in 1: selection strobe.
- `sel_idx` in $clog2(N_SLOTS): selected slot.
- `cancel` in 1: refund request.
- `price_flat` in N_SLOTS*PRICE_W: slot i price is at bits [i*PRICE_W +: PRICE_W]. A price of 0, or a price that is not a multiple of 5, marks the slot disabled.
- `restock_valid` in 1: add stock to a slot.
- `restock_idx` in $clog2(N_SLOTS): slot to restock.
- `restock_qty` in STOCK_W: quantity to add.
- `credit` out CREDIT_W: current credit, registered.
- `coin_reject` out 1: one-cycle pulse; the coin was returned unaccepted.
- `err_valid` out 1: one-cycle pulse.
- `err_code` out 2: 1 = disabled slot, 2 = out of stock, 3 = insufficient credit.
- `dispense_valid` out 1: vend request; held high until acknowledged.
- `dispense_idx` out $clog2(N_SLOTS): slot being vended.
- `dispense_ack` in 1: motor done.
- `change_valid` out 1: change coin offered.
- `change_coin` out 2: coin encoding as `coin_type`; only 0–2 are ever driven.
- `change_ready` in 1: hopper accepts the offered coin.

## Operation
- States: IDLE, VEND, CHANGE.
- IDLE, priority order cancel > sel > coin:
  - Cancel with credit > 0: go to CHANGE. Cancel with credit = 0: no-op.
  - Selection on a disabled slot, or with `sel_idx` ≥ N_SLOTS: error 1.
  - Selection with stock = 0: error 2.
  - Selection with credit < price: error 3.
  - Error cases stay in IDLE with credit unchanged.
  - Accepted selection: credit ← credit − price, stock[idx] decremented, go to VEND.
  - Coin: credit ← credit + value. If the new credit would exceed MAX_CREDIT, pulse `coin_reject` and leave credit unchanged.
  - A coin in the same cycle as a cancel or an accepted selection is rejected. A coin in the same cycle as a refused selection is processed normally.
- VEND:
  - `dispense_valid` = 1 and `dispense_idx` is stable.
  - On `dispense_ack`: go to CHANGE if credit > 0, otherwise IDLE.
  - `sel_valid` and `cancel` are ignored.
- CHANGE:
  - `change_coin` is the greedy largest of quarter, dime or nickel that is ≤ credit.
  - On `change_ready`, credit drops by that coin's value.
  - Leave for IDLE on the cycle credit reaches 0.
- Coins arriving in VEND or CHANGE are rejected.
- Restock is accepted in any state: stock[idx] ← sat(stock[idx] + qty).
- Restock and vend on the same slot in the same cycle: stock[idx] ← sat(stock[idx] − 1 + qty).
- Reset values:
  - State = IDLE, credit = 0, all stock = 0.
  - All outputs 0.
  - Reset mid-VEND or mid-CHANGE discards credit; there is no refund.

## Timing
- All outputs are registered.
- Coin at cycle t: `credit` updated at t+1, or `coin_reject` high at t+1.
- Selection at t: `err_valid`/`err_code` appear at t+1; on success, `dispense_valid` and the new credit appear at t+1.
- `dispense_ack` sampled at t with `dispense_valid` high: `dispense_valid` is low at t+1, and `change_valid` is high at t+1 if credit > 0.
- Change handshake: a coin transfers on the cycle `change_valid & change_ready`.
  - `change_valid` stays high, and `change_coin` stays stable, until the coin transfers.
  - The next coin is offered in the following cycle, giving 1 coin/cycle peak.
- Cancel at t: `change_valid` goes high at t+1.

## Structure
- Shared package `vending_pkg`:
  - Coin encoding constants and `coin_value` function.
  - Error-code constants.
  - State enum.
  - NICKEL / DIME / QUARTER / DOLLAR cent constants.
- Sub-module `vending_stock`:
  - N_SLOTS saturating counter array with one restock port and one decrement port.
  - Combinational `empty[idx]` read.
- Top level holds the FSM, credit register and the greedy change selector.

## Test plan
- Slot 2 priced 100, stock 3; insert 4 quarters; select 2; ack → credit 100 then 0, `dispense_idx` = 2, stock = 2, no change issued.
- Slot 0 priced 65; insert dollar; select 0; ack; `change_ready` held high → change coins quarter then dime (35), credit ends at 0, back in IDLE.
- Credit 25 with selection of a slot priced 150 → `err_code` 3 and credit stays 25. Selection of a stock-0 slot → `err_code` 2. Selection of a price-0 slot → `err_code` 1.
- Credit 975 plus dollar → `coin_reject`, credit stays 975. Coin and cancel in the same cycle → coin rejected, change stream totals 975 (39 quarters).
- Stock 15 (max, STOCK_W = 4); restock +3 → stock stays 15. Vend and restock +1 on the same slot in the same cycle → stock stays 15.
- `rst_n` low mid-CHANGE with credit 40 → next cycle: IDLE, credit 0, `change_valid` 0.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared coin, error and state definitions for the vending controller.
// Cent values are plain ints so callers can cast them to their own credit width.
package vending_pkg;

    localparam logic [1:0] COIN_NICKEL  = 2'd0;
    localparam logic [1:0] COIN_DIME    = 2'd1;
    localparam logic [1:0] COIN_QUARTER = 2'd2;
    localparam logic [1:0] COIN_DOLLAR  = 2'd3;

    localparam int NICKEL  = 5;
    localparam int DIME    = 10;
    localparam int QUARTER = 25;
    localparam int DOLLAR  = 100;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_DISABLED  = 2'd1;
    localparam logic [1:0] ERR_NO_STOCK  = 2'd2;
    localparam logic [1:0] ERR_NO_CREDIT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2
    } state_t;

    function automatic logic [6:0] coin_value(input logic [1:0] coin);
        case (coin)
            COIN_NICKEL:  return 7'(NICKEL);
            COIN_DIME:    return 7'(DIME);
            COIN_QUARTER: return 7'(QUARTER);
            default:      return 7'(DOLLAR);
        endcase
    endfunction

endpackage

// File: rtl/vending_stock.sv
// Per-slot saturating stock counters with one restock port and one decrement port.
// Updates land one cycle after the request; the empty flag is a combinational read.
module vending_stock #(
    parameter int N_SLOTS = 8,
    parameter int STOCK_W = 4,
    parameter int IDX_W   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               restock_valid,
    input  logic [IDX_W-1:0]   restock_idx,
    input  logic [STOCK_W-1:0] restock_qty,
    input  logic               dec_valid,
    input  logic [IDX_W-1:0]   dec_idx,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic               empty
);

    logic [STOCK_W-1:0] stock      [N_SLOTS];
    logic [STOCK_W-1:0] stock_next [N_SLOTS];
    logic [STOCK_W:0]   sum        [N_SLOTS];

    // Decrement is only requested on a non-empty slot, so sum never underflows;
    // the extra top bit flags overflow past the saturation point.
    always_comb begin
        for (int i = 0; i < N_SLOTS; i++) begin
            sum[i] = {1'b0, stock[i]};
            if (dec_valid && dec_idx == IDX_W'(i))
                sum[i] = sum[i] - (STOCK_W+1)'(1);
            if (restock_valid && restock_idx == IDX_W'(i))
                sum[i] = sum[i] + {1'b0, restock_qty};
            stock_next[i] = sum[i][STOCK_W] ? '1 : sum[i][STOCK_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SLOTS; i++)
                stock[i] <= '0;
        end else begin
            for (int i = 0; i < N_SLOTS; i++)
                stock[i] <= stock_next[i];
        end
    end

    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < N_SLOTS; i++)
            if (rd_idx == IDX_W'(i))
                empty = (stock[i] == '0);
    end

endmodule

// File: rtl/vending_ctrl.sv
// Vending controller: coin credit, slot validation, dispense handshake, greedy change stream.
// All outputs registered; coins during vend/change are rejected; change waits on change_ready.
module vending_ctrl
    import vending_pkg::*;
#(
    parameter int N_SLOTS    = 8,
    parameter int PRICE_W    = 10,
    parameter int CREDIT_W   = 11,
    parameter int MAX_CREDIT = 1000,
    parameter int STOCK_W    = 4,
    localparam int IDX_W     = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       coin_valid,
    input  logic [1:0]                 coin_type,
    input  logic                       sel_valid,
    input  logic [IDX_W-1:0]           sel_idx,
    input  logic                       cancel,
    input  logic [N_SLOTS*PRICE_W-1:0] price_flat,
    input  logic                       restock_valid,
    input  logic [IDX_W-1:0]           restock_idx,
    input  logic [STOCK_W-1:0]         restock_qty,
    output logic [CREDIT_W-1:0]        credit,
    output logic                       coin_reject,
    output logic                       err_valid,
    output logic [1:0]                 err_code,
    output logic                       dispense_valid,
    output logic [IDX_W-1:0]           dispense_idx,
    input  logic                       dispense_ack,
    output logic                       change_valid,
    output logic [1:0]                 change_coin,
    input  logic                       change_ready
);

    localparam int SUM_W = ((CREDIT_W > PRICE_W) ? CREDIT_W : PRICE_W) + 1;

    function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] c);
        if (c >= CREDIT_W'(QUARTER))   return COIN_QUARTER;
        else if (c >= CREDIT_W'(DIME)) return COIN_DIME;
        else                           return COIN_NICKEL;
    endfunction

    state_t              state, state_next;
    logic [CREDIT_W-1:0] credit_next;
    logic                reject_next, err_valid_next;
    logic [1:0]          err_code_next, change_coin_next;
    logic [IDX_W-1:0]    dispense_idx_next;
    logic                dispense_valid_next, change_valid_next;
    logic                dec_valid, slot_empty;

    logic [PRICE_W-1:0]  price;
    logic [SUM_W-1:0]    credit_x, price_x, coin_sum;
    logic                coin_fits, price_disabled;
    logic [1:0]          sel_err;
    logic [CREDIT_W-1:0] change_val, credit_after_change;

    // Out-of-range indices fall through with price 0 and so read as disabled.
    always_comb begin
        price = '0;
        for (int i = 0; i < N_SLOTS; i++)
            if (sel_idx == IDX_W'(i))
                price = price_flat[i*PRICE_W +: PRICE_W];
    end

    assign price_disabled = (price == '0) || ((price % PRICE_W'(NICKEL)) != '0);
    assign credit_x       = SUM_W'(credit);
    assign price_x        = SUM_W'(price);
    assign coin_sum       = credit_x + SUM_W'(coin_value(coin_type));
    assign coin_fits      = coin_sum <= SUM_W'(MAX_CREDIT);

    always_comb begin
        sel_err = ERR_NONE;
        if (price_disabled)         sel_err = ERR_DISABLED;
        else if (slot_empty)        sel_err = ERR_NO_STOCK;
        else if (credit_x < price_x) sel_err = ERR_NO_CREDIT;
    end

    assign change_val          = CREDIT_W'(coin_value(change_coin));
    assign credit_after_change = (credit > change_val) ? credit - change_val : '0;

    always_comb begin
        state_next        = state;
        credit_next       = credit;
        reject_next       = 1'b0;
        err_valid_next    = 1'b0;
        err_code_next     = ERR_NONE;
        dispense_idx_next = dispense_idx;
        dec_valid         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cancel) begin
                    reject_next = coin_valid;
                    if (credit != '0)
                        state_next = ST_CHANGE;
                end else if (sel_valid && sel_err == ERR_NONE) begin
                    reject_next       = coin_valid;
                    credit_next       = CREDIT_W'(credit_x - price_x);
                    dec_valid         = 1'b1;
                    dispense_idx_next = sel_idx;
                    state_next        = ST_VEND;
                end else begin
                    if (sel_valid) begin
                        err_valid_next = 1'b1;
                        err_code_next  = sel_err;
                    end
                    if (coin_valid) begin
                        if (coin_fits) credit_next = CREDIT_W'(coin_sum);
                        else           reject_next = 1'b1;
                    end
                end
            end
            ST_VEND: begin
                reject_next = coin_valid;
                if (dispense_ack)
                    state_next = (credit != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                reject_next = coin_valid;
                if (change_valid && change_ready) begin
                    credit_next = credit_after_change;
                    if (credit_after_change == '0)
                        state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Offer the next coin from the post-update credit so one coin moves per cycle.
        dispense_valid_next = (state_next == ST_VEND);
        change_valid_next   = (state_next == ST_CHANGE);
        change_coin_next    = change_valid_next ? greedy_coin(credit_next) : COIN_NICKEL;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            credit         <= '0;
            coin_reject    <= 1'b0;
            err_valid      <= 1'b0;
            err_code       <= ERR_NONE;
            dispense_valid <= 1'b0;
            dispense_idx   <= '0;
            change_valid   <= 1'b0;
            change_coin    <= COIN_NICKEL;
        end else begin
            state          <= state_next;
            credit         <= credit_next;
            coin_reject    <= reject_next;
            err_valid      <= err_valid_next;
            err_code       <= err_code_next;
            dispense_valid <= dispense_valid_next;
            dispense_idx   <= dispense_idx_next;
            change_valid   <= change_valid_next;
            change_coin    <= change_coin_next;
        end
    end

    vending_stock #(
        .N_SLOTS (N_SLOTS),
        .STOCK_W (STOCK_W),
        .IDX_W   (IDX_W)
    ) u_stock (
        .clk           (clk),
        .rst_n         (rst_n),
        .restock_valid (restock_valid),
        .restock_idx   (restock_idx),
        .restock_qty   (restock_qty),
        .dec_valid     (dec_valid),
        .dec_idx       (sel_idx),
        .rd_idx        (sel_idx),
        .empty         (slot_empty)
    );

endmodule

// File: tb/tb_vending_ctrl.sv
// Directed bench for vending_ctrl: a per-cycle vector table plus hand sequences
// for credit ceiling, long change streams, stock saturation and mid-change reset.
module tb_vending_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        coin_valid;
    logic [1:0]  coin_type;
    logic        sel_valid;
    logic [2:0]  sel_idx;
    logic        cancel;
    logic [79:0] price_flat;
    logic        restock_valid;
    logic [2:0]  restock_idx;
    logic [3:0]  restock_qty;
    logic [10:0] credit;
    logic        coin_reject;
    logic        err_valid;
    logic [1:0]  err_code;
    logic        dispense_valid;
    logic [2:0]  dispense_idx;
    logic        dispense_ack;
    logic        change_valid;
    logic [1:0]  change_coin;
    logic        change_ready;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vending_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .coin_valid     (coin_valid),
        .coin_type      (coin_type),
        .sel_valid      (sel_valid),
        .sel_idx        (sel_idx),
        .cancel         (cancel),
        .price_flat     (price_flat),
        .restock_valid  (restock_valid),
        .restock_idx    (restock_idx),
        .restock_qty    (restock_qty),
        .credit         (credit),
        .coin_reject    (coin_reject),
        .err_valid      (err_valid),
        .err_code       (err_code),
        .dispense_valid (dispense_valid),
        .dispense_idx   (dispense_idx),
        .dispense_ack   (dispense_ack),
        .change_valid   (change_valid),
        .change_coin    (change_coin),
        .change_ready   (change_ready)
    );

    typedef struct {
        string      name;
        logic       cv;
        logic [1:0] ct;
        logic       sv;
        logic [2:0] si;
        logic       cn;
        logic       ak;
        logic       rd;
        logic [10:0] e_credit;
        logic       e_rej;
        logic       e_ev;
        logic [1:0] e_ec;
        logic       e_dv;
        logic [2:0] e_di;
        logic       e_cv;
        logic [1:0] e_cc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string nm, logic cv, logic [1:0] ct, logic sv, logic [2:0] si,
                                logic cn, logic ak, logic rd, int cr, logic rej, logic ev,
                                logic [1:0] ec, logic dv, logic [2:0] di, logic co, logic [1:0] cc);
        vec_t v;
        v.name = nm; v.cv = cv; v.ct = ct; v.sv = sv; v.si = si; v.cn = cn; v.ak = ak; v.rd = rd;
        v.e_credit = 11'(cr); v.e_rej = rej; v.e_ev = ev; v.e_ec = ec;
        v.e_dv = dv; v.e_di = di; v.e_cv = co; v.e_cc = cc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cv, input logic [1:0] ct, input logic sv, input logic [2:0] si,
                         input logic cn, input logic ak);
        coin_valid = cv; coin_type = ct; sel_valid = sv; sel_idx = si;
        cancel = cn; dispense_ack = ak;
        step();
        coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0; dispense_ack = 1'b0;
    endtask

    task automatic restock(input logic [2:0] idx, input logic [3:0] qty);
        restock_valid = 1'b1; restock_idx = idx; restock_qty = qty;
        step();
        restock_valid = 1'b0;
    endtask

    task automatic drain(output int sum, output int cnt);
        sum = 0;
        cnt = 0;
        change_ready = 1'b1;
        for (int i = 0; i < 200 && change_valid; i++) begin
            case (change_coin)
                2'd0: sum += 5;
                2'd1: sum += 10;
                2'd2: sum += 25;
                default: sum += 100;
            endcase
            cnt++;
            step();
        end
        change_ready = 1'b0;
        chk("drain_done", change_valid, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [9:0] prices [8];
        int sum, cnt;
        prices = '{10'd65, 10'd150, 10'd100, 10'd0, 10'd5, 10'd12, 10'd25, 10'd5};
        for (int i = 0; i < 8; i++) price_flat[i*10 +: 10] = prices[i];

        rst_n = 1'b0; coin_valid = 1'b0; coin_type = 2'd0; sel_valid = 1'b0; sel_idx = 3'd0;
        cancel = 1'b0; restock_valid = 1'b0; restock_idx = 3'd0; restock_qty = 4'd0;
        dispense_ack = 1'b0; change_ready = 1'b0;
        step(); step();
        chk("rst_credit", credit, 0);
        chk("rst_reject", coin_reject, 0);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_disp_valid", dispense_valid, 0);
        chk("rst_disp_idx", dispense_idx, 0);
        chk("rst_chg_valid", change_valid, 0);
        chk("rst_chg_coin", change_coin, 0);
        rst_n = 1'b1;

        restock(3'd2, 4'd3);
        restock(3'd0, 4'd2);
        restock(3'd1, 4'd1);
        restock(3'd4, 4'd15);
        restock(3'd4, 4'd3);

        // name cv ct sv si cn ak rd | credit rej ev ec dv di cv cc
        tbl.push_back(mk("q1",        1,2, 0,0, 0,0,0,  25, 0, 0,0, 0,0, 0,0));
        tbl.push_back(mk("q2",        1,2, 0,0, 0,0,0,  50, 0, 0,0, 0,0, 0,0));
        tbl.push_back(mk("q3",        1,2, 0,0, 0,0,0,  75, 0, 0,0, 0,0, 0,0));
        tbl.push_back(mk("q4",        1,2, 0,0, 0,0,0, 100, 0, 0,0, 0,0, 0,0));
        tbl.push_back(mk("sel2",      0,0, 1,2, 0,0,0,   0, 0, 0,0, 1,2, 0,0));
        tbl.push_back(mk("vend_hold", 0,0, 0,0, 0,0,0,   0, 0, 0,0, 1,2, 0,0));
        tbl.push_back(mk("ack_nochg", 0,0, 0,0, 0,1,0,   0, 0, 0,0, 0,0, 0,0));
        tbl.push_back(mk("dollar",    1,3, 0,0, 0,0,0, 100, 0, 0,0, 0,0, 0,0));
        tbl.push_back(mk("sel0",      0,0, 1,0, 0,0,0,  35, 0, 0,0, 1,0, 0,0));
        tbl.push_back(mk("coin_vend", 1,0, 0,0, 0,0,0,  35, 1, 0,0, 1,0, 0,0));
        tbl.push_back(mk("ack_chg",   0,0, 0,0, 0,1,0,  35, 0, 0,0, 0,0, 1,2));
        tbl.push_back(mk("chg_wait",  0,0, 0,0, 0,0,0,  35, 0, 0,0, 0,0, 1,2));
        tbl.push_back(mk("chg_q",     0,0, 0,0, 0,0,1,  10, 0, 0,0, 0,0, 1,1));
        tbl.push_back(mk("chg_d",     0,0, 0,0, 0,0,1,   0, 0, 0,0, 0,0, 0,0));
        tbl.push_back(mk("err3_zero", 0,0, 1,0, 0,0,0,   0, 0, 1,3, 0,0, 0,0));
        tbl.push_back(mk("q5",        1,2, 0,0, 0,0,0,  25, 0, 0,0, 0,0, 0,0));
        tbl.push_back(mk("err3",      0,0, 1,1, 0,0,0,  25, 0, 1,3, 0,0, 0,0));
        tbl.push_back(mk("err2",      0,0, 1,7, 0,0,0,  25, 0, 1,2, 0,0, 0,0));
        tbl.push_back(mk("err1_zero", 0,0, 1,3, 0,0,0,  25, 0, 1,1, 0,0, 0,0));
        tbl.push_back(mk("err1_coin", 1,1, 1,5, 0,0,0,  35, 0, 1,1, 0,0, 0,0));
        tbl.push_back(mk("cancel",    0,0, 0,0, 1,0,0,  35, 0, 0,0, 0,0, 1,2));
        tbl.push_back(mk("coin_chg",  1,0, 0,0, 0,0,1,  10, 1, 0,0, 0,0, 1,1));
        tbl.push_back(mk("chg_end",   0,0, 0,0, 0,0,1,   0, 0, 0,0, 0,0, 0,0));

        foreach (tbl[k]) begin
            change_ready = tbl[k].rd;
            drive(tbl[k].cv, tbl[k].ct, tbl[k].sv, tbl[k].si, tbl[k].cn, tbl[k].ak);
            change_ready = 1'b0;
            chk({tbl[k].name, ".credit"}, credit, tbl[k].e_credit);
            chk({tbl[k].name, ".reject"}, coin_reject, tbl[k].e_rej);
            chk({tbl[k].name, ".err_valid"}, err_valid, tbl[k].e_ev);
            if (tbl[k].e_ev) chk({tbl[k].name, ".err_code"}, err_code, tbl[k].e_ec);
            chk({tbl[k].name, ".disp_valid"}, dispense_valid, tbl[k].e_dv);
            if (tbl[k].e_dv) chk({tbl[k].name, ".disp_idx"}, dispense_idx, tbl[k].e_di);
            chk({tbl[k].name, ".chg_valid"}, change_valid, tbl[k].e_cv);
            if (tbl[k].e_cv) chk({tbl[k].name, ".chg_coin"}, change_coin, tbl[k].e_cc);
        end

        // Credit ceiling, then coin+cancel and a 39-quarter refund stream.
        for (int i = 0; i < 9; i++) drive(1, 2'd3, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 2'd2, 0, 0, 0, 0);
        chk("fill_975", credit, 975);
        drive(1, 2'd3, 0, 0, 0, 0);
        chk("ceil_reject", coin_reject, 1);
        chk("ceil_credit", credit, 975);
        drive(1, 2'd2, 0, 0, 1, 0);
        chk("cancel_coin_reject", coin_reject, 1);
        chk("cancel_chg_valid", change_valid, 1);
        chk("cancel_credit", credit, 975);
        drain(sum, cnt);
        chk("refund_sum", sum, 975);
        chk("refund_count", cnt, 39);
        chk("refund_credit", credit, 0);

        // Slot 2 started with 3 and has one vend behind it: two more succeed, then empty.
        for (int i = 0; i < 2; i++) begin
            drive(1, 2'd3, 0, 0, 0, 0);
            drive(0, 0, 1, 3'd2, 0, 0);
            chk("slot2_vend", dispense_valid, 1);
            drive(0, 0, 0, 0, 0, 1);
            chk("slot2_ack", dispense_valid, 0);
        end
        drive(1, 2'd3, 0, 0, 0, 0);
        drive(0, 0, 1, 3'd2, 0, 0);
        chk("slot2_empty_ev", err_valid, 1);
        chk("slot2_empty_ec", err_code, 2);
        chk("slot2_empty_credit", credit, 100);
        drive(0, 0, 0, 0, 1, 0);
        drain(sum, cnt);
        chk("slot2_refund", sum, 100);

        // Slot 4 saturated at 15; vend with simultaneous +1 keeps it at 15.
        drive(1, 2'd0, 0, 0, 0, 0);
        restock_valid = 1'b1; restock_idx = 3'd4; restock_qty = 4'd1;
        drive(0, 0, 1, 3'd4, 0, 0);
        restock_valid = 1'b0;
        chk("slot4_vr_valid", dispense_valid, 1);
        chk("slot4_vr_idx", dispense_idx, 4);
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 15; i++) begin
            drive(1, 2'd0, 0, 0, 0, 0);
            drive(0, 0, 1, 3'd4, 0, 0);
            chk("slot4_vend", dispense_valid, 1);
            drive(0, 0, 0, 0, 0, 1);
        end
        drive(1, 2'd0, 0, 0, 0, 0);
        drive(0, 0, 1, 3'd4, 0, 0);
        chk("slot4_empty_ec", err_code, 2);
        chk("slot4_empty_ev", err_valid, 1);
        drive(0, 0, 0, 0, 1, 0);
        drain(sum, cnt);
        chk("slot4_refund", sum, 5);

        // Reset while change is pending discards the credit.
        drive(1, 2'd2, 0, 0, 0, 0);
        drive(1, 2'd1, 0, 0, 0, 0);
        drive(1, 2'd0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        chk("pre_rst_chg_valid", change_valid, 1);
        chk("pre_rst_credit", credit, 40);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midchg_rst_credit", credit, 0);
        chk("midchg_rst_chg_valid", change_valid, 0);
        drive(1, 2'd0, 0, 0, 0, 0);
        chk("post_rst_idle_coin", credit, 5);
        chk("post_rst_chg_valid", change_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
